// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
// Shared definitions for the runtime-programmable serial pattern detector:
// default geometry constants, the configuration bundle type for the default
// geometry, and the length-clamp rule applied when a configuration is loaded.
// -----------------------------------------------------------------------------
package seqdet_pkg;

    localparam int SEQDET_MAX_LEN = 8;
    localparam int SEQDET_COUNT_W = 8;
    localparam int SEQDET_LEN_W   = $clog2(SEQDET_MAX_LEN + 1);

    // Configuration bundle at the default geometry.
    typedef struct packed {
        logic [SEQDET_MAX_LEN-1:0] pattern;
        logic [SEQDET_LEN_W-1:0]   len;
        logic                      overlap;
    } seqdet_cfg_t;

    // A zero length loads as 1; anything longer than the history loads as
    // the full history length.
    function automatic int unsigned seqdet_clamp_len(input int unsigned len,
                                                     input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// -----------------------------------------------------------------------------
// seqdet_sat_counter
// Saturating up-counter for detector matches. Clear wins over increment and
// the count holds at all-ones instead of wrapping.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (count -> 0)
//   inc    count one event this cycle
//   clr    synchronous clear, priority over inc
//   count  current count
// -----------------------------------------------------------------------------
module seqdet_sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_sequence_detector.sv
// -----------------------------------------------------------------------------
// param_sequence_detector
// Runtime-programmable serial pattern detector with selectable overlapping or
// non-overlapping detection and a registered one-cycle match pulse.
//
// Build option: define SEQDET_COUNT_EN to include the saturating match counter.
// Without it match_count is tied to 0 and clr_count is ignored; detection is
// the same in both builds.
//
// Ports:
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   InD          serial data bit
//   in_valid     InD is sampled on an edge only while high
//   cfg_load     latch pattern/len/overlap and clear the detection history
//   cfg_pattern  pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length (0 loads as 1, >MAX_LEN loads as MAX_LEN)
//   cfg_overlap  1 = overlapping, 0 = non-overlapping detection
//   clr_count    synchronous clear of the match counter
//   match        one-cycle pulse after the edge that completed the pattern
//   match_count  saturating number of matches
// -----------------------------------------------------------------------------
module param_sequence_detector
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = SEQDET_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int COUNT_W = SEQDET_COUNT_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               InD,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [COUNT_W-1:0] match_count
);

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
        logic               overlap;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{pattern: '0, len: LEN_W'(MAX_LEN), overlap: 1'b1};

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    cfg_t               cfg_q, cfg_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cfg_d   = cfg_q;

        hist_n = {hist_q[MAX_LEN-2:0], InD};
        fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

        // Only the newest len bits of the history take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(cfg_q.len));
        end
        hit = (fill_n >= cfg_q.len) && (((hist_n ^ cfg_q.pattern) & len_mask) == '0);

        if (cfg_load) begin
            // A sample arriving with the load is dropped on purpose.
            cfg_d.pattern = cfg_pattern;
            cfg_d.len     = LEN_W'(seqdet_clamp_len(32'(cfg_len), 32'(MAX_LEN)));
            cfg_d.overlap = cfg_overlap;
            hist_d        = '0;
            fill_d        = '0;
        end else if (in_valid) begin
            match_d = hit;
            hist_d  = hist_n;
            // Non-overlap: the matched bits are consumed, so a fresh len bits
            // must arrive before the next hit.
            fill_d  = (hit && !cfg_q.overlap) ? '0 : fill_n;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cfg_q   <= CFG_RESET;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cfg_q   <= cfg_d;
        end
    end

    assign match = match_q;

`ifdef SEQDET_COUNT_EN
    // The counter bumps on the same edge that registers the match pulse.
    seqdet_sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_match_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (match_d),
        .clr   (clr_count),
        .count (match_count)
    );
`else
    logic unused_clr_count;
    assign unused_clr_count = clr_count;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_param_sequence_detector
// Self-checking bench for param_sequence_detector (MAX_LEN=8, COUNT_W=2).
// The reference model keeps the bits sampled since the last load/reset or
// consumed match in a queue and declares a match whenever the newest len bits
// read, oldest first, as pattern[len-1] .. pattern[0].
// -----------------------------------------------------------------------------
module tb_param_sequence_detector;
    import seqdet_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int COUNT_W = 2;
    localparam int CNT_MAX = 3;
`ifdef SEQDET_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic               CLK;
    logic               RST_N;
    logic               InD;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               match;
    logic [COUNT_W-1:0] match_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    seqdet_cfg_t        m_cfg;
    bit                 win[$];
    int                 m_cnt;
    logic               exp_match;
    logic [COUNT_W-1:0] exp_count;

    param_sequence_detector #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .InD         (InD),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .match       (match),
        .match_count (match_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_cfg.pattern = '0;
        m_cfg.len     = LEN_W'(MAX_LEN);
        m_cfg.overlap = 1'b1;
        win.delete();
        m_cnt     = 0;
        exp_match = 1'b0;
        exp_count = '0;
    endtask

    // Apply one clock of stimulus, advance the model, return at edge + 1.
    task automatic drive(input bit d, input bit v, input bit ld, input bit clr);
        int l;
        bit hit;
        InD       = d;
        in_valid  = v;
        cfg_load  = ld;
        clr_count = clr;
        exp_match = 1'b0;
        if (ld) begin
            l = int'(cfg_len);
            if (l < 1) l = 1;
            else if (l > MAX_LEN) l = MAX_LEN;
            m_cfg.pattern = cfg_pattern;
            m_cfg.len     = LEN_W'(l);
            m_cfg.overlap = cfg_overlap;
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > MAX_LEN) void'(win.pop_front());
            l   = int'(m_cfg.len);
            hit = (win.size() >= l);
            for (int j = 0; j < l && hit; j++) begin
                if (win[win.size() - l + j] != m_cfg.pattern[l - 1 - j]) hit = 1'b0;
            end
            exp_match = hit;
            if (hit && !m_cfg.overlap) win.delete();
        end
        if (clr) m_cnt = 0;
        else if (exp_match && m_cnt < CNT_MAX) m_cnt++;
        exp_count = COUNT_EN ? COUNT_W'(m_cnt) : '0;
        @(posedge CLK);
        #1;
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        clr_count = 1'b0;
    endtask

    // Load a configuration; a valid random sample rides along and must be dropped.
    task automatic load(input logic [7:0] pat, input int len, input bit ovl, input bit clr);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, clr);
        vectors++;
        if (match !== 1'b0 || match_count !== exp_count) begin
            miscompares++;
            $display("FAIL load: match=%b count=%0d expected match=0 count=%0d",
                     match, match_count, exp_count);
        end
    endtask

    // Stream n bits (bits[n-1] first), checking every cycle; returns matches seen.
    task automatic run_stream(input string name, input logic [31:0] bits, input int n,
                              output int nmatch);
        nmatch = 0;
        for (int i = n - 1; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0);
            vectors++;
            if (match !== exp_match || match_count !== exp_count) begin
                miscompares++;
                $display("FAIL %s bit %0d: match=%b count=%0d expected match=%b count=%0d",
                         name, n - i, match, match_count, exp_match, exp_count);
            end
            if (match === 1'b1) nmatch++;
        end
    endtask

    task automatic test_reset();
        int n;
        RST_N = 1'b0; InD = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #3;
        vectors++;
        if (match !== 1'b0 || match_count !== '0) begin
            miscompares++;
            $display("FAIL reset_state: match=%b count=%0d expected 0/0", match, match_count);
        end
        RST_N = 1'b1;
        // Reset config: pattern 0, len 8, overlap -> nine zeros give two matches.
        run_stream("reset_defaults", 32'h0, 9, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL reset_defaults_count: got %0d matches expected 2", n);
        end
    endtask

    task automatic test_basic();
        int n;
        load(8'b1100, 4, 1'b1, 1'b1);
        run_stream("basic_1100", 32'b11001100, 8, n);
        vectors++;
        if (n !== 2 || match_count !== (COUNT_EN ? 2'd2 : 2'd0)) begin
            miscompares++;
            $display("FAIL basic_total: matches=%0d count=%0d expected 2 and %0d",
                     n, match_count, COUNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_overlap();
        int n;
        load(8'b101, 3, 1'b1, 1'b1);
        run_stream("ovl_101", 32'b10101, 5, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL ovl_101_total: got %0d expected 2", n);
        end
        load(8'b101, 3, 1'b0, 1'b0);
        run_stream("novl_101", 32'b10101, 5, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL novl_101_total: got %0d expected 1", n);
        end
    endtask

    task automatic test_near_miss();
        int n;
        int total = 0;
        logic [3:0] misses [3] = '{4'b1101, 4'b0100, 4'b1000};
        for (int k = 0; k < 3; k++) begin
            load(8'b1100, 4, 1'b1, 1'b0);
            run_stream("near_miss", 32'(misses[k]), 4, n);
            total += n;
        end
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL near_miss_total: got %0d expected 0", total);
        end
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("lead_1_11100", 32'b11100, 5, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL lead_1_total: got %0d expected 1", n);
        end
    endtask

    task automatic test_gaps();
        int n;
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("gap_pre", 32'b110, 3, n);
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            vectors++;
            if (match !== exp_match) begin
                miscompares++;
                $display("FAIL gap_idle: match=%b expected %b", match, exp_match);
            end
        end
        run_stream("gap_last", 32'b0, 1, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL gap_total: got %0d expected 1", n);
        end
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("midload_pre", 32'b110, 3, n);
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("midload_post", 32'b0, 1, n);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL midload_post: got %0d expected 0", n);
        end
        run_stream("midload_refill", 32'b1100, 4, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL midload_refill: got %0d expected 1", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        load(8'b111, 3, 1'b1, 1'b1);
        run_stream("b2b_ovl", 32'b11111, 5, n);
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL b2b_ovl_total: got %0d expected 3", n);
        end
        load(8'b111, 3, 1'b0, 1'b0);
        run_stream("b2b_novl", 32'b111111, 6, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL b2b_novl_total: got %0d expected 2", n);
        end
    endtask

    task automatic test_async_reset();
        int n;
        // Reset while the pulse is high: it must drop before the next edge.
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("rst_hi_pre", 32'b1100, 4, n);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (match !== 1'b0 || match_count !== '0) begin
            miscompares++;
            $display("FAIL rst_async_hi: match=%b count=%0d expected 0/0", match, match_count);
        end
        #2 RST_N = 1'b1;
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("rst_mid_pre", 32'b1100110, 7, n);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (match !== 1'b0 || match_count !== '0) begin
            miscompares++;
            $display("FAIL rst_async_mid: match=%b count=%0d expected 0/0", match, match_count);
        end
        #2 RST_N = 1'b1;
        load(8'b1100, 4, 1'b1, 1'b0);
        run_stream("rst_post", 32'b1100, 4, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL rst_post_total: got %0d expected 1", n);
        end
    endtask

    task automatic test_counter_and_clamp();
        int n;
        load(8'b1, 1, 1'b1, 1'b1);
        run_stream("sat_ones", 32'b11111, 5, n);
        vectors++;
        if (n !== 5 || match_count !== (COUNT_EN ? 2'd3 : 2'd0)) begin
            miscompares++;
            $display("FAIL sat_hold: matches=%0d count=%0d expected 5 and %0d",
                     n, match_count, COUNT_EN ? 3 : 0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (match !== 1'b1 || match_count !== '0) begin
            miscompares++;
            $display("FAIL clr_vs_inc: match=%b count=%0d expected 1/0", match, match_count);
        end
        load(8'b1, 0, 1'b0, 1'b0);
        run_stream("clamp_len0", 32'b0110, 4, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL clamp_len0_total: got %0d expected 2", n);
        end
        load(8'hA5, 15, 1'b1, 1'b0);
        run_stream("clamp_len15", 32'hA5, 8, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL clamp_len15_total: got %0d expected 1", n);
        end
    endtask

    task automatic test_random();
        bit d, v, clr;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                load(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                               : $urandom_range(1, 4),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            end else begin
                d   = 1'($urandom_range(0, 1));
                v   = ($urandom_range(0, 4) != 0);
                clr = ($urandom_range(0, 31) == 0);
                drive(d, v, 1'b0, clr);
                vectors++;
                if (match !== exp_match || match_count !== exp_count) begin
                    miscompares++;
                    $display("FAIL random cycle %0d: match=%b count=%0d expected match=%b count=%0d",
                             c, match, match_count, exp_match, exp_count);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        test_counter_and_clamp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Runtime-programmable serial pattern detector. It is the parametrised successor of the fixed 4-bit "1100" detector. The pattern (up to MAX_LEN bits) and its length are loaded through a configuration port, and overlapping or non-overlapping detection is selectable. An optional saturating match counter is included. The block sits on a serial bit stream qualified by a valid strobe and produces a one-cycle registered match pulse.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- COUNT_W, 8: match counter width.

- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- InD  input  1  serial data bit.
- in_valid  input  1  InD is sampled on a rising edge only while this is high.
- cfg_load  input  1  latch the configuration and clear the detection history.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  input  1  synchronous clear of the match counter.
- match  output  1  one-cycle pulse; the pattern completed on the previous sampled bit.
- match_count  output  COUNT_W  saturating match count (SEQDET_COUNT_EN only).

## Operation
- Internal state:
  - hist: MAX_LEN-bit shift register.
  - fill: count of valid bits in hist, saturating at MAX_LEN.
  - Configuration registers: pat, len, ovl.
- Reset:
  - hist=0, fill=0, match=0, match_count=0.
  - pat=0, len=MAX_LEN, ovl=1.
- cfg_load=1:
  - Latches pattern, length and overlap mode.
  - Clears hist and fill, and forces match=0.
  - Any in_valid sample on the same edge is discarded.
  - match_count is not affected.
- Length clamping at load: cfg_len=0 loads as 1; cfg_len>MAX_LEN loads as MAX_LEN.
- Sample (in_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], InD}.
  - fill_n = min(fill+1, MAX_LEN).
  - hit = (fill_n ≥ len) and (hist_n[len-1:0] == pat[len-1:0]).
- Register updates on a sample:
  - match <= hit.
  - hist <= hist_n.
  - fill <= (hit and not ovl) ? 0 : fill_n.
- Non-overlap mode: after a hit, a fresh len bits are required before the next match. Overlap mode: the shared suffix counts toward the next match.
- No sample (in_valid=0): hist and fill hold; match <= 0.
- Bits of hist above len-1 are ignored in the compare.

## Timing
- Latency: match is high for exactly one cycle, following the edge that samples the final pattern bit.
- Back-to-back matches are possible in overlap mode: consecutive cycles for all-ones or all-zeros patterns.
- Gaps in in_valid do not break a partial match; history is preserved.
- Reset mid-stream: asynchronous; all outputs drop immediately. The first match after reset needs a full len valid samples.
- Counter:
  - Increments on the edge where match is registered high.
  - clr_count takes priority over a same-cycle increment; the result is 0.
  - Saturates at 2^COUNT_W-1; no wrap.

## Configuration
- SEQDET_COUNT_EN defined:
  - Match counter and the match_count port are present.
  - clr_count is functional.
- SEQDET_COUNT_EN undefined:
  - Counter logic is removed and match_count is driven constant 0.
  - clr_count is ignored.
  - Detection behaviour is identical in both builds.

## Structure
- Package seqdet_pkg holds:
  - default MAX_LEN and COUNT_W constants;
  - the length-clamp function;
  - a typedef for the configuration bundle (pattern, len, overlap).
- One sub-module, seqdet_sat_counter:
  - parametrised by COUNT_W;
  - inputs: inc, clr;
  - instantiated only under SEQDET_COUNT_EN.

## Test plan
1. RST_N low, then load pattern=1100, len=4, overlap=1; stream 1,1,0,0,1,1,0,0 with in_valid high → match pulses after the 4th and 8th bits; match_count=2.
2. Load pattern=101, len=3. Stream 1,0,1,0,1 with overlap=1 → matches after bits 3 and 5. Repeat with overlap=0 → single match after bit 3.
3. Load pattern=1100. Apply the near-miss streams 1101, 0100 and 1000, each after a fresh cfg_load → match never asserts. Then stream 11100 → one match after bit 5.
4. Load pattern=1100. Stream 1,1,0, drop in_valid for 3 cycles, then send 0 → match after the final bit. Repeat, but assert cfg_load mid-stream → no match until 4 new bits arrive.
5. Assert RST_N low after 1,1,0 of 1100 → match and match_count go to 0 immediately. The next 4-bit 1100 stream matches.
6. SEQDET_COUNT_EN build, COUNT_W=2:
   - five matches → match_count holds at 3;
   - clr_count coincident with a match → match_count=0.
